// File: rtl/irb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : irb_port_arbiter_if
// Description : Bundle of the two requester handshakes and the IRB memory
//               port shared through irb_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface irb_port_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    // Master 0 (LCD_CTRL write-back engine)
    logic              m0_req;
    logic              m0_rw;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    // Master 1 (display refresh scanner)
    logic              m1_req;
    logic              m1_rw;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    // Shared read data return
    logic [DATA_W-1:0] m_rdata;
    // IRB memory port
    logic [DATA_W-1:0] IRB_Q;
    logic              IRB_CEN;
    logic              IRB_RW;
    logic [ADDR_W-1:0] IRB_A;
    logic [DATA_W-1:0] IRB_D;
    // Status
    logic              idle;

    // Arbiter view
    modport slave (
        input  m0_req, m0_rw, m0_addr, m0_wdata,
        input  m1_req, m1_rw, m1_addr, m1_wdata,
        input  IRB_Q,
        output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m_rdata,
        output IRB_CEN, IRB_RW, IRB_A, IRB_D, idle
    );

    // Requester / memory-side view
    modport master (
        output m0_req, m0_rw, m0_addr, m0_wdata,
        output m1_req, m1_rw, m1_addr, m1_wdata,
        output IRB_Q,
        input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m_rdata,
        input  IRB_CEN, IRB_RW, IRB_A, IRB_D, idle
    );
endinterface
`default_nettype wire

// File: rtl/irb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : irb_port_arbiter
// Description : Round-robin arbiter sharing the single-port 64x8 IRB between
//               two masters, with burst locking, a bounded burst length and
//               per-master read-valid return.
// Revision    : 1.0 - initial release
// ============================================================================
module irb_port_arbiter #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    irb_port_arbiter_if.slave bus
);
    // One spare bit so MAX_BURST = 1 still yields a legal counter width
    localparam int               CNT_W      = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_prio;          // 0: m0 wins a tie, 1: m1 wins a tie
    logic              w_prio_nxt;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [CNT_W-1:0]  w_beat_cnt_nxt;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic              w_beat0;
    logic              w_beat1;
    logic              w_rw;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // A beat is the owner requesting; reset suppresses it in the same cycle
    assign w_beat0 = (r_state == S_OWN0) && bus.m0_req && !reset;
    assign w_beat1 = (r_state == S_OWN1) && bus.m1_req && !reset;

    // State, tie-break pointer, burst counter and read-return pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_prio     <= 1'b0;
            r_beat_cnt <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prio     <= w_prio_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_rvalid0  <= w_beat0 && bus.m0_rw;
            r_rvalid1  <= w_beat1 && bus.m1_rw;
        end
    end

    // Ownership decisions: idle arbitration, release handover, burst limit
    always_comb begin
        w_state_nxt    = r_state;
        w_prio_nxt     = r_prio;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.m0_req && (!bus.m1_req || !r_prio)) begin
                    w_state_nxt    = S_OWN0;
                    w_prio_nxt     = 1'b1;
                    w_beat_cnt_nxt = '0;
                end else if (bus.m1_req) begin
                    w_state_nxt    = S_OWN1;
                    w_prio_nxt     = 1'b0;
                    w_beat_cnt_nxt = '0;
                end
            end
            S_OWN0: begin
                if (bus.m0_req) begin
                    if (r_beat_cnt == C_CNT_LAST) begin
                        // Burst limit: yield only if the other side is waiting
                        w_beat_cnt_nxt = '0;
                        if (bus.m1_req) begin
                            w_state_nxt = S_OWN1;
                            w_prio_nxt  = 1'b0;
                        end
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + C_CNT_ONE;
                    end
                end else begin
                    w_beat_cnt_nxt = '0;
                    if (bus.m1_req) begin
                        w_state_nxt = S_OWN1;
                        w_prio_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_OWN1: begin
                if (bus.m1_req) begin
                    if (r_beat_cnt == C_CNT_LAST) begin
                        w_beat_cnt_nxt = '0;
                        if (bus.m0_req) begin
                            w_state_nxt = S_OWN0;
                            w_prio_nxt  = 1'b1;
                        end
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + C_CNT_ONE;
                    end
                end else begin
                    w_beat_cnt_nxt = '0;
                    if (bus.m0_req) begin
                        w_state_nxt = S_OWN0;
                        w_prio_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_beat_cnt_nxt = '0;
            end
        endcase
    end

    // Memory port mux: owner's request fields on a beat, quiet values otherwise
    always_comb begin
        w_rw    = 1'b1;
        w_addr  = '0;
        w_wdata = '0;
        if (w_beat0) begin
            w_rw    = bus.m0_rw;
            w_addr  = bus.m0_addr;
            w_wdata = bus.m0_wdata;
        end else if (w_beat1) begin
            w_rw    = bus.m1_rw;
            w_addr  = bus.m1_addr;
            w_wdata = bus.m1_wdata;
        end
    end

    assign bus.IRB_CEN   = !(w_beat0 || w_beat1);
    assign bus.IRB_RW    = w_rw;
    assign bus.IRB_A     = w_addr;
    assign bus.IRB_D     = w_wdata;

    // Grants and read strobes drop in the reset cycle itself
    assign bus.m0_gnt    = (r_state == S_OWN0) && !reset;
    assign bus.m1_gnt    = (r_state == S_OWN1) && !reset;
    assign bus.m0_rvalid = r_rvalid0 && !reset;
    assign bus.m1_rvalid = r_rvalid1 && !reset;
    assign bus.m_rdata   = bus.IRB_Q;
    assign bus.idle      = reset || ((r_state == S_IDLE) && !r_rvalid0 && !r_rvalid1);

endmodule
`default_nettype wire
